// File: rtl/seg7_capture.sv
// Receive side of a 7-segment bus: synchronise, debounce and decode
// the segment pattern into a hex digit on a ready/valid output.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    input  logic       clr_ovf,
    output logic [3:0] out_digit,
    output logic [6:0] out_raw,
    output logic       out_valid,
    output logic       ovf,
    output logic       bad_pulse,
    output logic [7:0] bad_count
);

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);
    localparam logic [6:0] LP_INV    = {7{ACTIVE_LOW}};

    logic [6:0] r_s1;
    logic [6:0] r_s2;
    logic [6:0] r_cand;
    logic [7:0] r_cnt;
    logic       r_acc;
    logic [6:0] r_last;
    logic [3:0] r_digit;
    logic [6:0] r_raw;
    logic       r_valid;
    logic       r_ovf;
    logic       r_bad_pulse;
    logic [7:0] r_bad_count;

    logic       w_hit;
    logic [3:0] w_dig;
    logic       w_accept;
    logic       w_new;
    logic       w_emit;
    logic       w_bad;
    logic       w_xfer;
    logic       w_drop;

    always_comb begin
        w_hit = 1'b1;
        w_dig = 4'h0;
        case (r_cand)
            7'h3F: w_dig = 4'h0;
            7'h06: w_dig = 4'h1;
            7'h5B: w_dig = 4'h2;
            7'h4F: w_dig = 4'h3;
            7'h66: w_dig = 4'h4;
            7'h6D: w_dig = 4'h5;
            7'h7D: w_dig = 4'h6;
            7'h07: w_dig = 4'h7;
            7'h7F: w_dig = 4'h8;
            7'h6F: w_dig = 4'h9;
            7'h77: w_dig = 4'hA;
            7'h7C: w_dig = 4'hB;
            7'h39: w_dig = 4'hC;
            7'h5E: w_dig = 4'hD;
            7'h79: w_dig = 4'hE;
            7'h71: w_dig = 4'hF;
            default: w_hit = 1'b0;
        endcase
    end

    // One acceptance per stable run; repeats of the last pattern are ignored
    assign w_accept = (r_cnt == LP_STABLE) && !r_acc;
    assign w_new    = w_accept && (r_cand != r_last);
    assign w_emit   = w_new && w_hit;
    assign w_bad    = w_new && !w_hit && (r_cand != 7'h00);
    assign w_xfer   = r_valid && out_ready;
    assign w_drop   = w_emit && r_valid && !w_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_acc       <= 1'b0;
            r_last      <= '0;
            r_digit     <= '0;
            r_raw       <= '0;
            r_valid     <= 1'b0;
            r_ovf       <= 1'b0;
            r_bad_pulse <= 1'b0;
            r_bad_count <= '0;
        end else begin
            r_s1 <= seg_in ^ LP_INV;
            r_s2 <= r_s1;

            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= 8'd1;
                r_acc  <= 1'b0;
            end else begin
                if (r_cnt < LP_STABLE) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if (w_accept) begin
                    r_acc <= 1'b1;
                end
            end

            if (w_new) begin
                r_last <= r_cand;
            end

            if (w_emit && (!r_valid || w_xfer)) begin
                r_digit <= w_dig;
                r_raw   <= r_cand;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            // A new overflow beats a simultaneous clear
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end

            r_bad_pulse <= w_bad;
            if (w_bad && (r_bad_count != 8'hFF)) begin
                r_bad_count <= r_bad_count + 8'd1;
            end
        end
    end

    assign out_digit = r_digit;
    assign out_raw   = r_raw;
    assign out_valid = r_valid;
    assign ovf       = r_ovf;
    assign bad_pulse = r_bad_pulse;
    assign bad_count = r_bad_count;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: an active-high and an active-low
// instance see the same logical patterns and must produce the same digits.
module tb_seg7_capture;

    localparam int SC = 4;
    localparam logic [6:0] TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       clr;
    logic [6:0] seg;
    logic [6:0] seg_al;

    logic [3:0] o0_digit, o1_digit;
    logic [6:0] o0_raw, o1_raw;
    logic       o0_valid, o1_valid;
    logic       o0_ovf, o1_ovf;
    logic       o0_bp, o1_bp;
    logic [7:0] o0_bc, o1_bc;

    int total = 0;
    int bad = 0;
    int bp0 = 0;
    int bp1 = 0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] e0, e1;

    logic [6:0] m_last;
    int         m_bad_ev = 0;
    int         m_badc = 0;

    assign seg_al = ~seg;

    always #5 clk = ~clk;

    seg7_capture #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .seg_in(seg), .out_ready(rdy),
        .clr_ovf(clr), .out_digit(o0_digit), .out_raw(o0_raw),
        .out_valid(o0_valid), .ovf(o0_ovf), .bad_pulse(o0_bp),
        .bad_count(o0_bc)
    );

    seg7_capture #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .seg_in(seg_al), .out_ready(rdy),
        .clr_ovf(clr), .out_digit(o1_digit), .out_raw(o1_raw),
        .out_valid(o1_valid), .ovf(o1_ovf), .bad_pulse(o1_bp),
        .bad_count(o1_bc)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every transfer must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (o0_bp) bp0++;
            if (o1_bp) bp1++;
            if (o0_valid && rdy) begin
                chk("xfer_expected_hi", 32'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    chk("digit_hi", 32'(o0_digit), 32'(e0[10:7]));
                    chk("raw_hi", 32'(o0_raw), 32'(e0[6:0]));
                end
            end
            if (o1_valid && rdy) begin
                chk("xfer_expected_lo", 32'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("digit_lo", 32'(o1_digit), 32'(e1[10:7]));
                    chk("raw_lo", 32'(o1_raw), 32'(e1[6:0]));
                end
            end
        end
    end

    // Reference: a run of n cycles is taken once n >= SC and it differs
    // from the last taken pattern; blank is taken silently.
    function automatic void model_run(input logic [6:0] p, input int n,
                                      input bit drop);
        bit hit;
        logic [3:0] d;
        hit = 1'b0;
        d = 4'h0;
        if (n >= SC && p != m_last) begin
            m_last = p;
            for (int i = 0; i < 16; i++) begin
                if (TAB[i] == p) begin
                    hit = 1'b1;
                    d = 4'(i);
                end
            end
            if (hit) begin
                if (!drop) begin
                    q0.push_back({d, p});
                    q1.push_back({d, p});
                end
            end else if (p != 7'h00) begin
                m_bad_ev++;
                if (m_badc < 255) m_badc++;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] p, input int n,
                        input bit drop = 1'b0);
        seg = p;
        model_run(p, n, drop);
        repeat (n) step();
    endtask

    task automatic drain(input string nm);
        repeat (12) step();
        chk({nm, "_q_hi_empty"}, 32'(q0.size()), 0);
        chk({nm, "_q_lo_empty"}, 32'(q1.size()), 0);
    endtask

    initial begin
        logic [6:0] p, prev;
        int n;
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        seg = 7'h00;
        m_last = 7'h00;
        repeat (3) step();
        chk("rst_valid", 32'(o0_valid), 0);
        chk("rst_digit", 32'(o0_digit), 0);
        chk("rst_raw", 32'(o0_raw), 0);
        chk("rst_ovf", 32'(o0_ovf), 0);
        chk("rst_bad_pulse", 32'(o0_bp), 0);
        chk("rst_bad_count", 32'(o0_bc), 0);
        chk("rst_valid_lo", 32'(o1_valid), 0);
        rst = 1'b0;
        step();

        // Latency: first sampled at edge E, valid at E+SC+2
        seg = 7'h06;
        model_run(7'h06, 20, 1'b0);
        repeat (SC + 2) @(posedge clk);
        #1;
        chk("lat_early_valid", 32'(o0_valid), 0);
        step();
        chk("lat_valid", 32'(o0_valid), 1);
        chk("lat_digit", 32'(o0_digit), 1);
        chk("lat_raw", 32'(o0_raw), 32'h06);
        step();
        chk("lat_single_pulse", 32'(o0_valid), 0);
        repeat (12) step();
        chk("t1_bad_count", 32'(o0_bc), 0);
        drain("t1");

        for (int i = 0; i < 16; i++) begin
            hold(TAB[i], 10);
            hold(7'h00, 10);
        end
        hold(7'h4F, 10);
        hold(7'h00, 10);
        hold(7'h4F, 10);
        hold(7'h00, 10);
        hold(7'h4F, 50);
        drain("sweep");

        hold(7'h00, 10);
        hold(7'h5B, SC - 1);
        hold(7'h7F, 10);
        drain("glitch");

        hold(7'h00, 10);
        rdy = 1'b0;
        hold(7'h66, 10);
        hold(7'h6D, 10, 1'b1);
        chk("bp_valid", 32'(o0_valid), 1);
        chk("bp_digit_held", 32'(o0_digit), 4);
        chk("bp_raw_held", 32'(o0_raw), 32'h66);
        chk("bp_ovf_hi", 32'(o0_ovf), 1);
        chk("bp_ovf_lo", 32'(o1_ovf), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf_hi", 32'(o0_ovf), 0);
        chk("clr_ovf_lo", 32'(o1_ovf), 0);
        rdy = 1'b1;
        step();
        chk("bp_valid_after_xfer", 32'(o0_valid), 0);
        drain("bp");

        hold(7'h00, 10);
        hold(7'h01, 10);
        hold(7'h00, 10);
        chk("inv_bad_count", 32'(o0_bc), 32'(m_badc));
        chk("inv_pulses", 32'(bp0), 32'(m_bad_ev));
        for (int i = 0; i < 300; i++) begin
            hold((i % 2 == 0) ? 7'h02 : 7'h01, SC);
        end
        hold(7'h00, 10);
        chk("sat_bad_count_hi", 32'(o0_bc), 255);
        chk("sat_bad_count_lo", 32'(o1_bc), 32'(m_badc));
        chk("sat_pulses_hi", 32'(bp0), 32'(m_bad_ev));
        drain("inv");

        prev = 7'h00;
        for (int i = 0; i < 80; i++) begin
            do begin
                case ($urandom_range(0, 9))
                    0: p = 7'h00;
                    1, 2: p = 7'($urandom_range(0, 127));
                    default: p = TAB[$urandom_range(0, 15)];
                endcase
            end while (p == prev);
            prev = p;
            n = $urandom_range(1, 12);
            hold(p, n);
        end
        hold(7'h00, 10);
        chk("rand_bad_count", 32'(o0_bc), 32'(m_badc));
        chk("rand_pulses_lo", 32'(bp1), 32'(m_bad_ev));
        drain("rand");

        // Reset with the run counter at 2 discards the partial run
        seg = 7'h6F;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_emit", 32'(o1_valid), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_last = 7'h00;
        m_badc = 0;
        chk("midrst_bad_count", 32'(o0_bc), 0);
        model_run(7'h6F, 40, 1'b0);
        repeat (SC + 2) @(posedge clk);
        #1;
        chk("midrst_early_valid", 32'(o1_valid), 0);
        step();
        chk("midrst_valid_lo", 32'(o1_valid), 1);
        chk("midrst_digit_lo", 32'(o1_digit), 9);
        chk("midrst_raw_lo", 32'(o1_raw), 32'h6F);
        repeat (30) step();
        drain("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive end of the 7-segment output bus: samples a seg[6:0] pattern, as driven on uo_out[6:0] by the display driver, and recovers the hex digit it encodes.
- Synchronises and debounces the pattern, decodes it, and presents each new digit on a ready/valid interface.
- Used as a self-check monitor on board and as a loopback checker in the tile.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples needed to accept a pattern; legal range 1..255.
- ACTIVE_LOW, 0: when 1, seg_in is inverted before any processing (common-anode displays).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- seg_in  in  7  segment bus; bit0=a … bit6=g; asynchronous to clk
- out_ready  in  1  consumer accepts out_digit this cycle
- clr_ovf  in  1  clears ovf
- out_digit  out  4  decoded hex digit
- out_raw  out  7  normalised (post-inversion) accepted pattern for out_digit
- out_valid  out  1  out_digit/out_raw valid
- ovf  out  1  sticky: a digit was dropped
- bad_pulse  out  1  one-cycle pulse: unrecognised pattern accepted
- bad_count  out  8  saturating count of unrecognised patterns

Behaviour:
- Reset (clk edge with rst=1):
  - All outputs 0.
  - Synchroniser flops s1/s2 = 0; candidate = 0; run counter = 0; last_accepted = 0x00 (blank); accepted flag = 0.
  - Reset mid-settle discards the partial run; reset with out_valid=1 drops the pending digit.
- Input path: s1 <= seg_in ^ {7{ACTIVE_LOW}}; s2 <= s1.
- Debounce:
  - If s2 != candidate: candidate <= s2, cnt <= 1, accepted <= 0.
  - Else if cnt < STABLE_CYCLES: cnt++.
  - Acceptance event is combinational when cnt == STABLE_CYCLES and accepted == 0. It sets accepted <= 1, so there is one event per stable run.
- Decode table, pattern -> digit: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F.
- On an acceptance event with pattern P:
  - If P == last_accepted: no action.
  - Else last_accepted <= P, then exactly one of:
    - P in table: emit.
    - P == 0x00 (blank): no emit. A later identical digit therefore re-emits.
    - Otherwise: bad_pulse = 1 for one cycle; bad_count++ saturating at 255; no emit.
- Latency:
  - Pattern first sampled into s1 at edge E. out_valid rises at edge E+STABLE_CYCLES+2, assuming no blocking.
  - Example: STABLE_CYCLES=4 gives out_valid at edge E+6.
- Output handshake:
  - Transfer occurs when out_valid && out_ready.
  - out_digit/out_raw are held stable while out_valid=1 and no transfer has occurred.
  - Emit with out_valid=0: load digit, out_valid <= 1.
  - Emit with out_valid=1 and transfer in the same cycle: load the new digit, out_valid stays 1, no ovf.
  - Emit with out_valid=1 and no transfer: new digit dropped, current digit kept, ovf <= 1.
  - No emit and transfer: out_valid <= 0.
- ovf:
  - Cleared by clr_ovf.
  - clr_ovf and a new overflow in the same cycle leaves ovf = 1 (set wins).
- Glitches: any s2 change before cnt reaches STABLE_CYCLES restarts the run; a shorter pattern is never decoded.
- out_ready is ignored while out_valid=0.

Test Plan:
- Reset, then seg_in=0x06 held 20 cycles, out_ready=1 -> single out_valid pulse 6 edges after first sample, out_digit=1, out_raw=0x06; bad_count=0.
- Sweep all 16 table patterns, each held 10 cycles with blank 0x00 between, out_ready=1 -> 16 transfers with digits 0..F in order; then 0x4F, 0x00, 0x4F -> digit 3 twice; 0x4F held 50 cycles -> one transfer only.
- Glitch: 0x5B for 3 cycles, then 0x7F held, STABLE_CYCLES=4 -> only digit 8 emitted; no digit 2.
- Backpressure: out_ready=0, patterns 0x66 then 0x6D (each 10 cycles) -> out_digit stays 4, ovf=1; clr_ovf pulse -> ovf=0; out_ready=1 -> digit 4 transferred, out_valid=0 the next cycle.
- Invalid: seg_in=0x01 for 10 cycles -> one bad_pulse, bad_count=1, no out_valid; 300 alternating 0x01/0x02 runs -> bad_count saturates at 255.
- ACTIVE_LOW=1 with seg_in=~0x6F (0x10) -> out_digit=9, out_raw=0x6F; assert rst mid-run (cnt=2) -> no emit; the pattern re-settles and is emitted after the full latency.
